// File: rtl/onehot_stream_checker.sv
// Registered one-hot / zero-or-one-hot / one-cold stream monitor with
// one-cycle result latency, saturating violation count and first-offender capture.
module onehot_stream_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(DATA_WIDTH),
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [1:0]            mode,
    input  logic                  clear,
    output logic                  out_valid,
    output logic                  onehot,
    output logic                  is_zero,
    output logic [IDX_WIDTH-1:0]  index,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  err_sticky,
    output logic [DATA_WIDTH-1:0] first_bad
);

    logic [DATA_WIDTH-1:0] inv;
    logic                  din_zero;
    logic                  single;
    logic                  pass;
    logic [IDX_WIDTH-1:0]  enc;
    logic [CNT_WIDTH-1:0]  cnt_base;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  sticky_base;

    // One-cold is checked as one-hot of the inverted word, so the cold
    // position falls out of the same encoder.
    assign inv      = (mode == 2'b10) ? ~din : din;
    assign din_zero = ~|din;
    assign single   = (|inv) && ((inv & (inv - DATA_WIDTH'(1))) == '0);
    assign pass     = single || ((mode == 2'b01) && din_zero);

    always_comb begin
        enc = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (inv[i]) enc = enc | IDX_WIDTH'(i);
        end
    end

    // clear takes effect before a same-cycle failing sample is counted.
    assign cnt_base    = clear ? '0 : err_count;
    assign sticky_base = clear ? 1'b0 : err_sticky;
    assign cnt_next    = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            onehot     <= 1'b0;
            is_zero    <= 1'b0;
            index      <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
            first_bad  <= '0;
        end else begin
            out_valid <= din_valid;
            if (din_valid) begin
                onehot  <= pass;
                is_zero <= din_zero;
                index   <= pass ? enc : '0;
            end
            if (clear) begin
                err_count  <= '0;
                err_sticky <= 1'b0;
                first_bad  <= '0;
            end
            if (din_valid && !pass) begin
                err_count  <= cnt_next;
                err_sticky <= 1'b1;
                if (!sticky_base) first_bad <= din;
            end
        end
    end

endmodule

// File: tb/tb_onehot_stream_checker.sv
// Randomized and directed bench for onehot_stream_checker (DATA_WIDTH=8,
// CNT_WIDTH=3) against a popcount-based reference model.
module tb_onehot_stream_checker;

    localparam int DW = 8;
    localparam int IW = 3;
    localparam int CW = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          resetn;
    logic          din_valid;
    logic [DW-1:0] din;
    logic [1:0]    mode;
    logic          clear;
    logic          out_valid;
    logic          onehot;
    logic          is_zero;
    logic [IW-1:0] index;
    logic [CW-1:0] err_count;
    logic          err_sticky;
    logic [DW-1:0] first_bad;

    onehot_stream_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din_valid  (din_valid),
        .din        (din),
        .mode       (mode),
        .clear      (clear),
        .out_valid  (out_valid),
        .onehot     (onehot),
        .is_zero    (is_zero),
        .index      (index),
        .err_count  (err_count),
        .err_sticky (err_sticky),
        .first_bad  (first_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference state
    logic          m_ov;
    logic          m_onehot;
    logic          m_zero;
    int            m_index;
    int            m_cnt;
    logic          m_sticky;
    logic [DW-1:0] m_first;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ov = 0; m_onehot = 0; m_zero = 0; m_index = 0;
        m_cnt = 0; m_sticky = 0; m_first = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"},  32'(out_valid),  32'(m_ov));
        check({tag, ".onehot"},     32'(onehot),     32'(m_onehot));
        check({tag, ".is_zero"},    32'(is_zero),    32'(m_zero));
        check({tag, ".index"},      32'(index),      32'(m_index));
        check({tag, ".err_count"},  32'(err_count),  32'(m_cnt));
        check({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
        check({tag, ".first_bad"},  32'(first_bad),  32'(m_first));
    endtask

    // Applies one cycle of stimulus, advances the model, checks after the edge.
    task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                        input logic [1:0] m, input logic c);
        int  ones;
        int  pos;
        bit  ok;
        din_valid = v; din = d; mode = m; clear = c;
        @(posedge clk);
        ones = 0;
        for (int i = 0; i < DW; i++) ones += int'(d[i]);
        case (m)
            2'b01:   ok = (ones <= 1);
            2'b10:   ok = (ones == DW - 1);
            default: ok = (ones == 1);
        endcase
        pos = 0;
        if (ok) for (int i = 0; i < DW; i++)
            if (d[i] == (m != 2'b10)) pos = i;
        m_ov = v;
        if (v) begin
            m_onehot = ok;
            m_zero   = (ones == 0);
            m_index  = ok ? pos : 0;
        end
        if (c) begin
            m_cnt = 0; m_sticky = 0; m_first = '0;
        end
        if (v && !ok) begin
            if (!m_sticky) m_first = d;
            m_sticky = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
        check_all(tag);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        logic [DW-1:0] one;
        one = 1;
        case ($urandom_range(0, 4))
            0:       w = one << $urandom_range(0, DW - 1);
            1:       w = ~(one << $urandom_range(0, DW - 1));
            2:       w = '0;
            3:       w = '1;
            default: w = DW'($urandom);
        endcase
        return w;
    endfunction

    initial begin
        resetn = 0; din_valid = 0; din = '0; mode = 2'b00; clear = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        resetn = 1;

        step("hot10",   1, 8'h10, 2'b00, 0);
        check("hot10.index_const", 32'(index), 32'd4);
        step("multi18", 1, 8'h18, 2'b00, 0);
        step("zero00",  1, 8'h00, 2'b00, 0);
        check("zero00.first_bad_const", 32'(first_bad), 32'h18);
        step("z_mode01", 1, 8'h00, 2'b01, 0);
        step("cold_fb",  1, 8'hFB, 2'b10, 0);
        check("cold_fb.index_const", 32'(index), 32'd2);
        step("cold_ff",  1, 8'hFF, 2'b10, 0);
        step("rsvd_m11", 1, 8'h40, 2'b11, 0);
        step("rsvd_bad", 1, 8'h41, 2'b11, 0);

        step("clr", 0, 8'h00, 2'b00, 1);
        for (int i = 0; i < 9; i++) step("sat03", 1, 8'h03, 2'b00, 0);
        check("sat.count_const", 32'(err_count), 32'd7);
        step("clr_fail81", 1, 8'h81, 2'b00, 1);
        check("clr_fail81.count_const", 32'(err_count), 32'd1);

        step("gap_a", 1, 8'h01, 2'b00, 0);
        step("gap_idle", 0, 8'hFF, 2'b00, 0);
        step("gap_b", 1, 8'h80, 2'b00, 0);

        // Build err_count=5, then drop reset with a sample in flight.
        step("pre_clr", 0, 8'h00, 2'b00, 1);
        for (int i = 0; i < 5; i++) step("pre_fail", 1, 8'h00, 2'b00, 0);
        din_valid = 1; din = 8'h20; mode = 2'b00; clear = 0;
        #2;
        resetn = 0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("in_rst");
        @(negedge clk);
        din_valid = 0;
        resetn = 1;
        step("post_rst", 0, 8'h00, 2'b00, 0);

        for (int n = 0; n < 400; n++)
            step("rand", 1'($urandom_range(0, 3) != 0), rand_word(),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onehot_stream_checker.md
Name: onehot_stream_checker

Overview:
- Registered, streaming successor to the combinational one-hot detector.
- Checks a valid-qualified input word every cycle against a selectable code mode: strict one-hot, zero-or-one-hot, or one-cold.
- Reports the result and the hot-bit index one cycle later.
- Keeps a saturating violation counter, a sticky error flag and a capture of the first offending word.
- Sits on control/select buses (arbiter grants, mux selects, FSM state vectors) as a protocol monitor.

Parameters:
- DATA_WIDTH, 32: width of din; legal range 2..256.
- IDX_WIDTH, $clog2(DATA_WIDTH): width of index; derived, not overridden.
- CNT_WIDTH, 8: width of the saturating violation counter.

Ports:
- clk  input  1: clock, all state on rising edge.
- resetn  input  1: asynchronous active-low reset.
- din_valid  input  1: din and mode are sampled this cycle.
- din  input  DATA_WIDTH: word under test.
- mode  input  2: check mode. 00 = strict one-hot; 01 = one-hot-or-zero; 10 = one-cold (exactly one 0 bit); 11 = reserved, behaves as 00.
- clear  input  1: synchronous clear of err_count, err_sticky and first_bad.
- out_valid  output  1: result outputs are meaningful this cycle.
- onehot  output  1: 1 = sampled word legal for its mode.
- is_zero  output  1: sampled din was all zeros. Independent of mode.
- index  output  IDX_WIDTH: bit position of the single hot bit. In mode 10 it is the position of the single 0 bit. 0 when onehot=0 or din was all zeros.
- err_count  output  CNT_WIDTH: number of failing valid samples, saturating.
- err_sticky  output  1: set by any failing valid sample; held until clear.
- first_bad  output  DATA_WIDTH: din of the first failing sample since reset/clear.

Behaviour:
- Reset (resetn=0, asynchronous): all outputs go to 0 immediately: out_valid, onehot, is_zero, index, err_count, err_sticky, first_bad.
- Reset release is synchronous to clk. The first sample is the first edge with resetn=1.
- Latency is exactly 1 cycle, with no backpressure. A sample at edge N gives out_valid=1 and its results after edge N.
- With din_valid=0, out_valid=0 next cycle. onehot, is_zero and index hold their previous values. Counters and capture are unchanged.
- Pass rules, with popcount = number of 1s in din:
  - mode 00/11: pass iff popcount == 1.
  - mode 01: pass iff popcount <= 1.
  - mode 10: pass iff popcount == DATA_WIDTH-1.
- Index is computed only from a passing word. It is the binary encoding of the single hot (or cold) position. An all-zero pass in mode 01 gives index=0 and is_zero=1.
- The implementation must not use a data-dependent loop exit. Use a fixed-structure check (e.g. x & (x-1) plus a non-zero check) and an OR-tree encoder.
- Fail on a valid sample:
  - err_count increments by 1, saturating at 2^CNT_WIDTH-1 (never wraps).
  - err_sticky is set.
  - first_bad captures din only if err_sticky was 0 before this edge.
- clear=1 at an edge: err_count, err_sticky and first_bad reset. If din_valid=1 with a failing sample in the same cycle, clear is applied first and the sample then counts: err_count=1, err_sticky=1, first_bad=din.
- clear does not affect out_valid, onehot, is_zero or index.
- A mode change takes effect on the sample it accompanies. There is no mode pipeline state.
- resetn asserted mid-stream drops everything to reset values at once. An in-flight sample is lost (no out_valid).

Test Plan:
- DATA_WIDTH=8, mode=00, din=0x10 valid -> next cycle out_valid=1, onehot=1, index=4, is_zero=0, err_count=0.
- mode=00, din=0x18 then din=0x00 back-to-back -> two cycles of onehot=0, index=0; err_count=2, err_sticky=1, first_bad=0x18; second result has is_zero=1.
- mode=01, din=0x00 -> onehot=1, is_zero=1, index=0, no error. mode=10, din=0xFB -> onehot=1, index=2. mode=10, din=0xFF -> onehot=0, err_count+1.
- CNT_WIDTH=3, 9 consecutive failing samples (din=0x03) -> err_count reaches 7 and holds; first_bad=0x03. Then clear together with failing din=0x81 -> err_count=1, first_bad=0x81.
- Gap: valid, idle, valid (din=0x01, -, 0x80) -> out_valid pattern 1,0,1; index 0, held 0, 7; counters unchanged through the idle cycle.
- Drop resetn asynchronously mid-cycle with err_count=5 and a sample in flight -> all outputs 0 before the next edge; no out_valid for the in-flight sample after release.
